// File: rtl/exec_controller.sv
// rtl/exec_controller.sv - step/run/speed/edit execution controller for a small core (optional EXEC_CTRL_STEP_COUNT_EN step counter)
module exec_controller #(
    parameter int RUN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        NEXT,
    input  logic        RUN,
    input  logic        SPEEDRUN,
    input  logic        edit,
    input  logic        send,
    input  logic [7:0]  unit,
    input  logic [7:0]  code,
    input  logic        halt,
    output logic        step,
    output logic        rom_we,
    output logic [7:0]  rom_addr,
    output logic [7:0]  rom_data,
    output logic [2:0]  mode,
    output logic        busy
`ifdef EXEC_CTRL_STEP_COUNT_EN
    ,
    output logic [15:0] step_count
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_SPEED  = 3'd2,
        ST_EDIT   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam logic [7:0] PRESC_LAST = 8'(RUN_DIV - 1);

    state_t     state;
    logic [7:0] prescaler;

    logic next_prev;
    logic run_prev;
    logic speed_prev;
    logic edit_prev;
    logic send_prev;

    logic next_rise;
    logic run_rise;
    logic speed_rise;
    logic edit_rise;
    logic send_rise;
    logic enter_edit;

    assign next_rise  = NEXT & ~next_prev;
    assign run_rise   = RUN & ~run_prev;
    assign speed_rise = SPEEDRUN & ~speed_prev;
    assign edit_rise  = edit & ~edit_prev;
    assign send_rise  = send & ~send_prev;

    // HALTED only leaves on a fresh edit press; every other non-edit state jumps on the level
    assign enter_edit = (state != ST_EDIT) &&
                        (((state != ST_HALTED) && edit) || ((state == ST_HALTED) && edit_rise));

    assign mode = state;

    // Main FSM: edit beats halt, halt beats buttons, SPEEDRUN > RUN > NEXT among buttons
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            prescaler  <= 8'd0;
            step       <= 1'b0;
            rom_we     <= 1'b0;
            rom_addr   <= 8'd0;
            rom_data   <= 8'd0;
            busy       <= 1'b0;
            next_prev  <= NEXT;
            run_prev   <= RUN;
            speed_prev <= SPEEDRUN;
            edit_prev  <= edit;
            send_prev  <= send;
        end else begin
            next_prev  <= NEXT;
            run_prev   <= RUN;
            speed_prev <= SPEEDRUN;
            edit_prev  <= edit;
            send_prev  <= send;
            step       <= 1'b0;
            rom_we     <= 1'b0;
            if (state == ST_EDIT) begin
                if (send_rise) begin
                    rom_we   <= 1'b1;
                    rom_addr <= unit;
                    rom_data <= code;
                end
                if (!edit) begin
                    state <= ST_IDLE;
                end
            end else if (enter_edit) begin
                state <= ST_EDIT;
                busy  <= 1'b0;
            end else if ((state != ST_HALTED) && halt) begin
                state <= ST_HALTED;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (speed_rise) begin
                            state <= ST_SPEED;
                            busy  <= 1'b1;
                        end else if (run_rise) begin
                            state     <= ST_RUN;
                            prescaler <= 8'd0;
                            busy      <= 1'b1;
                        end else if (next_rise) begin
                            step <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (speed_rise) begin
                            state <= ST_SPEED;
                        end else if (run_rise) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (prescaler == PRESC_LAST) begin
                            prescaler <= 8'd0;
                            step      <= 1'b1;
                        end else begin
                            prescaler <= prescaler + 8'd1;
                        end
                    end
                    ST_SPEED: begin
                        if (speed_rise) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (run_rise) begin
                            state     <= ST_RUN;
                            prescaler <= 8'd0;
                        end else begin
                            step <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef EXEC_CTRL_STEP_COUNT_EN
    // Counts step pulses as they appear on the output; entering EDIT restarts the count
    always_ff @(posedge clk) begin
        if (rst || enter_edit) begin
            step_count <= 16'd0;
        end else if (step) begin
            step_count <= step_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/exec_controller.md
EXEC_CONTROLLER -- requirements
Module: exec_controller

Interface
REQ-001 SHALL have parameter RUN_DIV, default 4, meaning the number of clk cycles between step pulses in RUN mode; legal range 2..255.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port NEXT  input  1  single-step button, level.
REQ-005 SHALL have port RUN  input  1  run/stop toggle button, level.
REQ-006 SHALL have port SPEEDRUN  input  1  full-speed toggle button, level.
REQ-007 SHALL have port edit  input  1  program-edit mode request, level.
REQ-008 SHALL have port send  input  1  program-word write button, level.
REQ-009 SHALL have port unit  input  8  program ROM address to write.
REQ-010 SHALL have port code  input  8  program ROM data to write.
REQ-011 SHALL have port halt  input  1  core has decoded HALT.
REQ-012 SHALL have port step  output  1  one-cycle core-advance enable.
REQ-013 SHALL have port rom_we  output  1  one-cycle ROM write strobe.
REQ-014 SHALL have port rom_addr  output  8  ROM write address.
REQ-015 SHALL have port rom_data  output  8  ROM write data.
REQ-016 SHALL have port mode  output  3  state: 0 IDLE, 1 RUN, 2 SPEED, 3 EDIT, 4 HALTED.
REQ-017 SHALL have port busy  output  1  high in RUN or SPEED.

Function
REQ-018 SHALL edge-detect NEXT, RUN, SPEEDRUN, send, edit via one registered previous-value flop each; rise = in & ~prev.
REQ-019 SHALL register all outputs; step, rom_we are single-cycle pulses.
REQ-020 IDLE: NEXT rise at edge t -> step=1 during cycle t+1 only; stay IDLE.
REQ-021 IDLE: RUN rise -> RUN; SPEEDRUN rise -> SPEED; simultaneous rises priority SPEEDRUN > RUN > NEXT, lower ones discarded.
REQ-022 RUN: prescaler cleared on entry, counts 0..RUN_DIV-1 and wraps; step=1 in the cycle after prescaler == RUN_DIV-1; first step RUN_DIV cycles after entry.
REQ-023 SPEED: step=1 every cycle, first in the cycle after entry.
REQ-024 RUN: RUN rise -> IDLE; SPEEDRUN rise -> SPEED. SPEED: SPEEDRUN rise -> IDLE; RUN rise -> RUN. NEXT ignored in both.
REQ-025 halt=1 sampled in RUN, SPEED or IDLE -> HALTED; step=0 from next cycle; halt overrides button rises in the same cycle.
REQ-026 HALTED: NEXT, RUN, SPEEDRUN ignored; exit only via rst or edit rise (-> EDIT).
REQ-027 edit=1 in any state -> EDIT next cycle, priority over all buttons and halt; step=0 from that cycle.
REQ-028 EDIT: send rise at edge t -> rom_we=1 in cycle t+1 with rom_addr=unit, rom_data=code sampled at t; rom_addr/rom_data hold until next write.
REQ-029 EDIT: edit low -> IDLE; a send rise in the same cycle still produces its write.
REQ-030 rom_we SHALL never assert outside EDIT (or the exit cycle of REQ-029); step SHALL never assert in EDIT or HALTED.

Reset
REQ-031 rst SHALL override all inputs; next state IDLE, step=0, rom_we=0, rom_addr=0, rom_data=0, busy=0, mode=0, prescaler=0.
REQ-032 During rst the edge-detect flops SHALL load current inputs, so buttons held through reset produce no rise on release.
REQ-033 rst mid-RUN/SPEED/EDIT SHALL abort with no further step or rom_we pulse.

Configuration
REQ-034 With EXEC_CTRL_STEP_COUNT_EN defined: output step_count (16 bits) increments on every step pulse, wraps 0xFFFF->0x0000, cleared by rst and on entry to EDIT.
REQ-035 Without EXEC_CTRL_STEP_COUNT_EN: port step_count and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-036 rst, IDLE, NEXT pulse 2 cycles -> exactly one step pulse, one cycle after the rise; mode stays 0.
REQ-037 edit=1, unit=5, code=0x12, send rise -> rom_we one cycle, rom_addr=5, rom_data=0x12; edit low -> mode 0.
REQ-038 RUN_DIV=4, RUN rise -> step at cycles 4, 8, 12 after entry; second RUN rise -> mode 0, no further steps.
REQ-039 SPEEDRUN rise, 10 cycles, halt=1 -> 10 consecutive step pulses, then mode 4, step=0; NEXT/RUN ignored afterward.
REQ-040 RUN held high through rst release -> mode 0, no step; with macro, step_count=0, after 3 NEXT pulses step_count=3.
